// File: rtl/btb_assoc_if.sv
// Fetch/backend interface of the branch target buffer.
//   master: drives lookup_valid/lookup_pc, the upd_* training bus and flush;
//           receives btb_hit/btb_target.
//   slave : the BTB itself.
interface btb_assoc_if #(
    parameter int unsigned PC_BITS = 32
);
    logic               lookup_valid;
    logic [PC_BITS-1:0] lookup_pc;
    logic               btb_hit;
    logic [PC_BITS-1:0] btb_target;
    logic               upd_valid;
    logic               upd_taken;
    logic [PC_BITS-1:0] upd_pc;
    logic [PC_BITS-1:0] upd_target;
    logic               flush;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_taken, upd_pc, upd_target, flush,
        input  btb_hit, btb_target
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_taken, upd_pc, upd_target, flush,
        output btb_hit, btb_target
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with flop storage.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : btb_assoc_if.slave
//                lookup_valid/lookup_pc -> btb_hit/btb_target one cycle later
//                upd_valid/upd_taken/upd_pc/upd_target train at the clock edge
//                flush invalidates every entry (and drops a same-cycle update)
// Each entry holds valid, partial tag, 2-bit confidence counter and target[PC_BITS-1:2].
// Each set holds a round-robin victim pointer used only when all ways are valid.
module btb_assoc #(
    parameter int unsigned SETS     = 64,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned TAG_BITS = 12,
    parameter int unsigned PC_BITS  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_assoc_if.slave  bus
);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TGT_BITS = PC_BITS - 2;
    localparam int unsigned TAG_LSB  = IDX_BITS + 2;

    typedef logic [WAY_BITS-1:0] way_t;

    logic                valid_q  [SETS][WAYS];
    logic [1:0]          ctr_q    [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
    logic [TGT_BITS-1:0] tgt_q    [SETS][WAYS];
    way_t                victim_q [SETS];

    logic [PC_BITS-1:0]  pc_q;
    logic                lookup_valid_q;

    // Update-side decode
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    way_t                hit_way;
    logic                has_inv;
    way_t                inv_way;
    way_t                wr_way;
    logic                do_upd;
    logic                wr_data;

    assign upd_idx = bus.upd_pc[TAG_LSB-1:2];
    assign upd_tag = bus.upd_pc[TAG_LSB +: TAG_BITS];
    assign do_upd  = bus.upd_valid && !bus.flush;
    assign wr_data = do_upd && bus.upd_taken;

    // Matching way and lowest-index invalid way (descending scan so lowest wins)
    always_comb begin
        upd_hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[upd_idx][w]) begin
                has_inv = 1'b1;
                inv_way = way_t'(w);
            end
            if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
                upd_hit = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    assign wr_way = upd_hit ? hit_way : (has_inv ? inv_way : victim_q[upd_idx]);

    // Lookup side: read the registered set straight from the array, so an update
    // landing on the same edge as the lookup register is already visible.
    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic                hit_c;
    logic [PC_BITS-1:0]  target_c;

    assign rd_idx = pc_q[TAG_LSB-1:2];
    assign rd_tag = pc_q[TAG_LSB +: TAG_BITS];

    always_comb begin
        hit_c    = 1'b0;
        target_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (lookup_valid_q && valid_q[rd_idx][w] && ctr_q[rd_idx][w][1]
                && (tag_q[rd_idx][w] == rd_tag)) begin
                hit_c    = 1'b1;
                target_c = {tgt_q[rd_idx][w], 2'b00};
            end
        end
    end

    assign bus.btb_hit    = hit_c;
    assign bus.btb_target = target_c;

    // Control state: valid bits, counters, victim pointers, lookup register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b00;
                end
                victim_q[s] <= '0;
            end
            pc_q           <= '0;
            lookup_valid_q <= 1'b0;
        end else begin
            pc_q           <= bus.lookup_pc;
            lookup_valid_q <= bus.lookup_valid;
            if (bus.flush) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    for (int w = 0; w < int'(WAYS); w++) begin
                        valid_q[s][w] <= 1'b0;
                    end
                end
            end else if (bus.upd_valid) begin
                if (bus.upd_taken) begin
                    if (upd_hit) begin
                        if (ctr_q[upd_idx][wr_way] != 2'd3) begin
                            ctr_q[upd_idx][wr_way] <= ctr_q[upd_idx][wr_way] + 2'd1;
                        end
                    end else begin
                        valid_q[upd_idx][wr_way] <= 1'b1;
                        ctr_q[upd_idx][wr_way]   <= 2'b10;
                        // Pointer only moves when a valid entry is evicted
                        if (!has_inv && (WAYS > 1)) begin
                            victim_q[upd_idx] <= victim_q[upd_idx] + way_t'(1);
                        end
                    end
                end else if (upd_hit) begin
                    ctr_q[upd_idx][wr_way] <= ctr_q[upd_idx][wr_way] - 2'd1;
                    // Never leave a valid entry at counter 0
                    if (ctr_q[upd_idx][wr_way] == 2'd1) begin
                        valid_q[upd_idx][wr_way] <= 1'b0;
                    end
                end
            end
        end
    end

    // Payload storage: tag and target, written on taken allocate/refresh
    always_ff @(posedge clk) begin
        if (wr_data) begin
            tag_q[upd_idx][wr_way] <= upd_tag;
            tgt_q[upd_idx][wr_way] <= bus.upd_target[PC_BITS-1:2];
        end
    end

    // Low PC bits and bits above the partial tag carry no information here
    logic unused_bits;
    assign unused_bits = ^{pc_q, bus.upd_pc, bus.upd_target[1:0]};

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (SETS=64, WAYS=2, TAG_BITS=12, PC_BITS=32).
module tb_btb_assoc;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    btb_assoc_if #(.PC_BITS(32)) bus ();

    btb_assoc #(
        .SETS(64), .WAYS(2), .TAG_BITS(12), .PC_BITS(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (entries as plain integers) ----------------
    bit          m_valid [64][2];
    int          m_tag   [64][2];
    int          m_ctr   [64][2];
    logic [31:0] m_tgt   [64][2];
    int          m_vic   [64];
    bit          m_lv = 1'b0;
    logic [31:0] m_pc = 32'h0;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_ctr[s][w]   = 0;
            end
            m_vic[s] = 0;
        end
        m_lv = 1'b0;
        m_pc = 32'h0;
    endtask

    task automatic model_train(input bit taken, input logic [31:0] pc, input logic [31:0] tgt);
        int s, t, hw, aw;
        s  = int'((pc >> 2) % 64);
        t  = int'((pc >> 8) % 4096);
        hw = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (taken) begin
            if (hw >= 0) begin
                if (m_ctr[s][hw] < 3) m_ctr[s][hw] = m_ctr[s][hw] + 1;
                m_tgt[s][hw] = tgt & ~32'h3;
            end else begin
                aw = -1;
                for (int w = 0; w < 2; w++)
                    if (!m_valid[s][w] && aw < 0) aw = w;
                if (aw < 0) begin
                    aw       = m_vic[s];
                    m_vic[s] = (m_vic[s] + 1) % 2;
                end
                m_valid[s][aw] = 1'b1;
                m_ctr[s][aw]   = 2;
                m_tag[s][aw]   = t;
                m_tgt[s][aw]   = tgt & ~32'h3;
            end
        end else if (hw >= 0) begin
            m_ctr[s][hw] = m_ctr[s][hw] - 1;
            if (m_ctr[s][hw] == 0) m_valid[s][hw] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (bus.flush) begin
            for (int s = 0; s < 64; s++)
                for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end else if (bus.upd_valid) begin
            model_train(bus.upd_taken, bus.upd_pc, bus.upd_target);
        end
        m_lv = bus.lookup_valid;
        m_pc = bus.lookup_pc;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    task automatic model_expect(output bit hit, output logic [31:0] tgt);
        int s, t;
        hit = 1'b0;
        tgt = 32'h0;
        s   = int'((m_pc >> 2) % 64);
        t   = int'((m_pc >> 8) % 4096);
        if (m_lv) begin
            for (int w = 0; w < 2; w++) begin
                if (m_valid[s][w] && m_tag[s][w] == t && m_ctr[s][w] >= 2) begin
                    hit = 1'b1;
                    tgt = m_tgt[s][w];
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input bit exp_hit, input logic [31:0] exp_tgt);
        n_checks++;
        if (bus.btb_hit !== exp_hit || bus.btb_target !== exp_tgt) begin
            n_fail++;
            $display("FAIL %s: got hit=%0b target=%h, expected hit=%0b target=%h (t=%0t)",
                     name, bus.btb_hit, bus.btb_target, exp_hit, exp_tgt, $time);
        end
    endtask

    // Every cycle: outputs must match the model (outputs depend only on flops)
    always @(negedge clk) begin
        bit          eh;
        logic [31:0] et;
        model_expect(eh, et);
        check("model", eh, et);
    end

    // ---------------- stimulus ----------------
    // One call = one clock cycle of inputs
    task automatic drive(input bit lv, input logic [31:0] lpc,
                         input bit uv, input bit ut, input logic [31:0] upc,
                         input logic [31:0] utgt, input bit fl);
        @(negedge clk);
        bus.lookup_valid = lv;
        bus.lookup_pc    = lpc;
        bus.upd_valid    = uv;
        bus.upd_taken    = ut;
        bus.upd_pc       = upc;
        bus.upd_target   = utgt;
        bus.flush        = fl;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic train(input bit taken, input logic [31:0] pc, input logic [31:0] tgt);
        drive(1'b0, 32'h0, 1'b1, taken, pc, tgt, 1'b0);
    endtask

    // Literal check of the lookup issued in the most recently driven cycle
    task automatic lit(input string name, input bit exp_hit, input logic [31:0] exp_tgt);
        @(posedge clk);
        #1;
        check(name, exp_hit, exp_tgt);
    endtask

    localparam logic [31:0] PA  = 32'h6000_0100; // set 0 tag 1
    localparam logic [31:0] PB  = 32'h6000_0200; // set 0 tag 2
    localparam logic [31:0] PC  = 32'h6000_0300; // set 0 tag 3
    localparam logic [31:0] PD  = 32'h6000_0400; // set 0 tag 4
    localparam logic [31:0] PA1 = 32'h6000_0104; // set 1
    localparam logic [31:0] PA2 = 32'h6000_0108; // set 2
    localparam logic [31:0] PB2 = 32'h6000_0208;
    localparam logic [31:0] PC2 = 32'h6000_0308;
    localparam logic [31:0] PE  = 32'h6000_010C; // set 3

    initial begin
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = 32'h0;
        bus.upd_valid    = 1'b0;
        bus.upd_taken    = 1'b0;
        bus.upd_pc       = 32'h0;
        bus.upd_target   = 32'h0;
        bus.flush        = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_out", 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold lookup misses
        look(PA);                                    lit("cold_miss", 1'b0, 32'h0);

        // Same-cycle train + lookup is visible (write-through)
        drive(1'b1, PA, 1'b1, 1'b1, PA, 32'h6000_0240, 1'b0);
        lit("write_through", 1'b1, 32'h6000_0240);

        // Fill set 0, third tag evicts way 0 (A), pointer -> 1
        train(1'b1, PB, 32'h6000_0440);
        train(1'b1, PC, 32'h6000_0640);
        look(PA);                                    lit("evicted_a", 1'b0, 32'h0);
        look(PB);                                    lit("b_hit", 1'b1, 32'h6000_0440);
        look(PC);                                    lit("c_hit", 1'b1, 32'h6000_0640);
        // Pointer now 1: next eviction removes B
        train(1'b1, PD, 32'h6000_0740);
        look(PB);                                    lit("evicted_b", 1'b0, 32'h0);
        look(PC);                                    lit("c_kept", 1'b1, 32'h6000_0640);
        look(PD);                                    lit("d_hit", 1'b1, 32'h6000_0740);

        // Counter behaviour in set 1
        drive(1'b1, PA1, 1'b1, 1'b1, PA1, 32'h6000_0500, 1'b0);
        lit("a1_alloc", 1'b1, 32'h6000_0500);
        drive(1'b1, PA1, 1'b1, 1'b0, PA1, 32'h0, 1'b0);
        lit("a1_ctr1_miss", 1'b0, 32'h0);
        drive(1'b1, PA1, 1'b1, 1'b0, PA1, 32'h0, 1'b0);
        lit("a1_invalid", 1'b0, 32'h0);
        drive(1'b1, PA1, 1'b1, 1'b1, PA1, 32'h6000_0504, 1'b0);
        lit("a1_realloc", 1'b1, 32'h6000_0504);
        train(1'b1, PA1, 32'h6000_0504);
        train(1'b1, PA1, 32'h6000_0508);
        look(PA1);                                   lit("a1_saturate", 1'b1, 32'h6000_0508);
        train(1'b0, PA1, 32'h0);
        train(1'b0, PA1, 32'h0);
        look(PA1);                                   lit("a1_decay", 1'b0, 32'h0);

        // Flush wins over a same-cycle update
        train(1'b1, PA2, 32'h6000_0800);
        drive(1'b1, PA2, 1'b1, 1'b1, PB2, 32'h6000_0900, 1'b0);
        lit("a2_hit", 1'b1, 32'h6000_0800);
        drive(1'b1, PB2, 1'b1, 1'b1, PC2, 32'h6000_0A00, 1'b1);
        lit("flush_b2", 1'b0, 32'h0);
        look(PA2);                                   lit("flush_a2", 1'b0, 32'h0);
        look(PC2);                                   lit("flush_c2", 1'b0, 32'h0);
        look(PC);                                    lit("flush_c", 1'b0, 32'h0);

        // Asynchronous reset drops outputs mid-cycle
        train(1'b1, PE, 32'h6000_0C00);
        look(PE);                                    lit("e_hit", 1'b1, 32'h6000_0C00);
        #1 rst_n = 1'b0;
        #1 check("async_reset", 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        look(PE);                                    lit("e_after_reset", 1'b0, 32'h0);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
